// File: rtl/cc_miss_ctrl.sv
// cc_miss_ctrl - miss-handling sequencer placed behind the tag comparator.
//
// A comparator hit is served in the same cycle. A miss stalls the front end,
// issues one line-fill read burst, streams the returned beats into the data
// SRAM, writes the tag SRAM entry as valid and then emits a serve pulse for
// the original request.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   hit_i, miss_i                    comparator result pulses
//   tag_i, index_i, offset_i         fields of the compared request
//   stall_o                          front end must not handshake while high
//   serve_o, serve_offset_o/index_o  one-cycle serve pulse with request fields
//   mem_ar*                          fill read request channel
//   mem_r*                           fill read data channel
//   data_w*                          data SRAM write port (one beat per write)
//   tag_w*                           tag SRAM write port {valid, tag}
//   err_o                            sticky: rlast disagreed with beat count
module cc_miss_ctrl #(
    parameter  int DATA_W = 64,
    localparam int BEATS  = 512 / DATA_W,
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hit_i,
    input  logic              miss_i,
    input  logic [16:0]       tag_i,
    input  logic [8:0]        index_i,
    input  logic [5:0]        offset_i,
    output logic              stall_o,
    output logic              serve_o,
    output logic [5:0]        serve_offset_o,
    output logic [8:0]        serve_index_o,
    output logic              mem_arvalid_o,
    input  logic              mem_arready_i,
    output logic [31:0]       mem_araddr_o,
    input  logic              mem_rvalid_i,
    output logic              mem_rready_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_rlast_i,
    output logic              data_wren_o,
    output logic [8:0]        data_waddr_o,
    output logic [CNT_W-1:0]  data_wbeat_o,
    output logic [DATA_W-1:0] data_wdata_o,
    output logic              tag_wren_o,
    output logic [8:0]        tag_waddr_o,
    output logic [17:0]       tag_wdata_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_FILL   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [16:0]       tag_q, tag_d;
    logic [8:0]        index_q, index_d;
    logic [5:0]        offset_q, offset_d;
    logic              err_q, err_d;
    logic              last_beat_s;

    // The counter, not rlast, decides where the line ends.
    assign last_beat_s = (cnt_q == CNT_W'(BEATS - 1));

    // Next-state, beat counter, request latch and error flag.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tag_d    = tag_q;
        index_d  = index_q;
        offset_d = offset_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (miss_i) begin
                    tag_d    = tag_i;
                    index_d  = index_i;
                    offset_d = offset_i;
                    state_d  = ST_REQ;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_arready_i) begin
                    cnt_d   = '0;
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_FILL: begin
                if (mem_rvalid_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_beat_s) begin
                        err_d   = err_q | ~mem_rlast_i;
                        state_d = ST_UPDATE;
                    end else begin
                        err_d   = err_q | mem_rlast_i;
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_UPDATE: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            tag_q    <= 17'd0;
            index_q  <= 9'd0;
            offset_q <= 6'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tag_q    <= tag_d;
            index_q  <= index_d;
            offset_q <= offset_d;
            err_q    <= err_d;
        end
    end

    // Output decode: memory-side outputs depend only on registered state, so
    // no mem_*_i input reaches a mem_*_o output; the data SRAM write follows
    // the accepted beat in the same cycle.
    always_comb begin
        serve_o        = 1'b0;
        serve_offset_o = 6'd0;
        serve_index_o  = 9'd0;
        mem_arvalid_o  = 1'b0;
        mem_araddr_o   = 32'd0;
        mem_rready_o   = 1'b0;
        data_wren_o    = 1'b0;
        data_waddr_o   = 9'd0;
        data_wbeat_o   = '0;
        data_wdata_o   = '0;
        tag_wren_o     = 1'b0;
        tag_waddr_o    = 9'd0;
        tag_wdata_o    = 18'd0;
        // A miss stalls in its own cycle so the front end never handshakes it.
        stall_o        = (state_q != ST_IDLE) | miss_i;
        err_o          = err_q;
        case (state_q)
            ST_IDLE: begin
                if (hit_i) begin
                    serve_o        = 1'b1;
                    serve_offset_o = offset_i;
                    serve_index_o  = index_i;
                end else begin
                    serve_o        = 1'b0;
                end
            end
            ST_REQ: begin
                mem_arvalid_o = 1'b1;
                mem_araddr_o  = {tag_q, index_q, 6'd0};
            end
            ST_FILL: begin
                mem_rready_o = 1'b1;
                if (mem_rvalid_i) begin
                    data_wren_o  = 1'b1;
                    data_waddr_o = index_q;
                    data_wbeat_o = cnt_q;
                    data_wdata_o = mem_rdata_i;
                end else begin
                    data_wren_o  = 1'b0;
                end
            end
            ST_UPDATE: begin
                tag_wren_o  = 1'b1;
                tag_waddr_o = index_q;
                tag_wdata_o = {1'b1, tag_q};
            end
            ST_DONE: begin
                serve_o        = 1'b1;
                serve_offset_o = offset_q;
                serve_index_o  = index_q;
            end
            default: begin
                serve_o = 1'b0;
            end
        endcase
    end

endmodule
